// File: rtl/seg_steer_pkg.sv
// seg_steer_pkg: shared state encoding and default tuning constants for steering enable.
// The DWELL state only exists when SEG_STEER_DWELL_EN is defined.
package seg_steer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
`ifdef SEG_STEER_DWELL_EN
    ,
    DWELL = 2'd3
`endif
  } state_t;
  localparam int MIN_RIDER_WT = 'h200;
  localparam int HYST         = 'h020;
  localparam int SETTLE_CYC   = 65000000;
endpackage

// File: rtl/steer_settle_tmr.sv
// steer_settle_tmr: saturating up-counter; full while the count sits at CYC-1.
module steer_settle_tmr #(
  parameter int CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic full
);
  localparam int W = $clog2(CYC);
  logic [W-1:0] cnt;
  assign full = cnt == W'(CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt_en && !full) cnt <= cnt + 1'b1;
endmodule

// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider-presence FSM gating steering from left/right load cells.
// Define SEG_STEER_DWELL_EN to add the step-off DWELL state with its DWELL_CYC counter.
module steer_en_ctrl
  import seg_steer_pkg::*;
#(
  parameter int LOAD_W       = 12,
  parameter int MIN_RIDER_WT = seg_steer_pkg::MIN_RIDER_WT,
  parameter int HYST         = seg_steer_pkg::HYST,
  parameter int SETTLE_CYC   = seg_steer_pkg::SETTLE_CYC,
  parameter int DWELL_CYC    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_vld,
  input  logic [LOAD_W-1:0]        lft_load,
  input  logic [LOAD_W-1:0]        rght_load,
  output logic                     en_steer,
  output logic                     rider_off,
  output logic signed [LOAD_W:0]   load_cell_diff,
  output logic [1:0]               steer_state
);
  localparam logic [LOAD_W:0] SUM_HI = (LOAD_W + 1)'(MIN_RIDER_WT + HYST);
  localparam logic [LOAD_W:0] SUM_LO = (LOAD_W + 1)'(MIN_RIDER_WT - HYST);
  if (SETTLE_CYC < 2 || DWELL_CYC < 2) begin : g_bad_cfg
    $error("steer_en_ctrl: SETTLE_CYC and DWELL_CYC must be >= 2");
  end
  state_t state, nxt;
  logic [LOAD_W-1:0] lft_q, rght_q;
  logic [LOAD_W:0] sum, abs_diff;
  logic signed [LOAD_W:0] diff;
  logic sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
  logic tmr_clr, tmr_full, act_q;
  assign sum           = {1'b0, lft_q} + {1'b0, rght_q};
  assign diff          = $signed({1'b0, lft_q}) - $signed({1'b0, rght_q});
  assign abs_diff      = diff[LOAD_W] ? $unsigned(-diff) : $unsigned(diff);
  assign sum_gt_min    = sum > SUM_HI;
  assign sum_lt_min    = sum < SUM_LO;
  assign diff_gt_1_4   = abs_diff > (sum >> 2);
  assign diff_gt_15_16 = abs_diff > sum - (sum >> 4);
  assign steer_state   = state;
  steer_settle_tmr #(.CYC(SETTLE_CYC)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .cnt_en (state == WAIT),
    .full   (tmr_full)
  );
`ifdef SEG_STEER_DWELL_EN
  logic dwell_full;
  steer_settle_tmr #(.CYC(DWELL_CYC)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != DWELL),
    .cnt_en (1'b1),
    .full   (dwell_full)
  );
`endif
  always_comb begin
    nxt     = state;
    tmr_clr = 1'b0;
    case (state)
      IDLE: if (sum_gt_min) begin
        nxt     = WAIT;
        tmr_clr = 1'b1;
      end
      WAIT: if (sum_lt_min) nxt = IDLE;
        else if (diff_gt_1_4) tmr_clr = 1'b1;
        else if (tmr_full) nxt = STEER;
`ifdef SEG_STEER_DWELL_EN
      STEER: if (sum_lt_min) nxt = IDLE;
        else if (diff_gt_15_16) nxt = DWELL;
      DWELL: if (sum_lt_min) nxt = IDLE;
        else if (!diff_gt_15_16) nxt = STEER;
        else if (dwell_full) begin
          nxt     = WAIT;
          tmr_clr = 1'b1;
        end
`else
      STEER: if (sum_lt_min) nxt = IDLE;
        else if (diff_gt_15_16) begin
          nxt     = WAIT;
          tmr_clr = 1'b1;
        end
`endif
      default: nxt = IDLE;
    endcase
  end
  // en_steer and rider_off trail the state register by one clock; act_q remembers the prior state.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      lft_q          <= '0;
      rght_q         <= '0;
      load_cell_diff <= '0;
      act_q          <= 1'b0;
      en_steer       <= 1'b0;
      rider_off      <= 1'b0;
    end else begin
      state     <= nxt;
      act_q     <= state != IDLE;
      en_steer  <= state[1];
      rider_off <= act_q && state == IDLE;
      if (load_vld) begin
        lft_q          <= lft_load;
        rght_q         <= rght_load;
        load_cell_diff <= $signed({1'b0, lft_load}) - $signed({1'b0, rght_load});
      end
    end
endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb_steer_en_ctrl: directed scenarios plus random load traffic against a behavioural rider model.
module tb_steer_en_ctrl;
  localparam int SETTLE = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_vld = 1'b0;
  logic [11:0] lft_load = '0, rght_load = '0;
  logic en_steer, rider_off;
  logic signed [12:0] load_cell_diff;
  logic [1:0] steer_state;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  steer_en_ctrl #(
    .LOAD_W       (12),
    .MIN_RIDER_WT ('h200),
    .HYST         ('h020),
    .SETTLE_CYC   (SETTLE),
    .DWELL_CYC    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_vld       (load_vld),
    .lft_load       (lft_load),
    .rght_load      (rght_load),
    .en_steer       (en_steer),
    .rider_off      (rider_off),
    .load_cell_diff (load_cell_diff),
    .steer_state    (steer_state)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // Model: rider phase 0=absent, 1=settling, 2=steering; m_w counts undisturbed settling clocks.
  int m_l = 0, m_r = 0, m_st = 0, m_w = 0, h1 = 0, h2 = 0;
  int s, d, ad;
  logic [12:0] m_diff = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_l = 0; m_r = 0; m_st = 0; m_w = 0; h1 = 0; h2 = 0; m_diff = '0;
    end else begin
      s  = m_l + m_r;
      d  = m_l - m_r;
      ad = d < 0 ? -d : d;
      h2 = h1;
      h1 = m_st;
      if (m_st == 0) begin
        if (s > 'h220) begin m_st = 1; m_w = 0; end
      end else if (m_st == 1) begin
        if (s < 'h1E0) m_st = 0;
        else if (ad > s / 4) m_w = 0;
        else begin
          m_w++;
          if (m_w == SETTLE) m_st = 2;
        end
      end else begin
        if (s < 'h1E0) m_st = 0;
        else if (ad > s - s / 16) begin m_st = 1; m_w = 0; end
      end
      if (load_vld) begin
        m_l = int'(lft_load);
        m_r = int'(rght_load);
        m_diff = {1'b0, lft_load} - {1'b0, rght_load};
      end
    end
    #1;
    chk("steer_state", 32'(steer_state), 32'(m_st));
    chk("en_steer", 32'(en_steer), 32'(h1 == 2));
    chk("rider_off", 32'(rider_off), 32'(h1 == 0 && h2 != 0));
    chk("load_cell_diff", 32'($unsigned(load_cell_diff)), 32'(m_diff));
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic load(input int l, input int r);
    lft_load  = 12'(l);
    rght_load = 12'(r);
    load_vld  = 1'b1;
    tick();
    load_vld  = 1'b0;
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, k, v;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_en", 32'(en_steer), 0);
    chk("rst_roff", 32'(rider_off), 0);
    chk("rst_diff", 32'($unsigned(load_cell_diff)), 0);
    chk("rst_state", 32'(steer_state), 0);
    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(steer_state), 0);
    load('h151, 'h14F);
    chk("diff_after_vld", 32'($unsigned(load_cell_diff)), 2);
    chk("capture_only", 32'(steer_state), 0);
    tick();
    chk("enter_wait", 32'(steer_state), 1);
    n = 0;
    while (!en_steer && n < 40) begin tick(); n++; end
    chk("settle_latency", n, 17);
    chk("steer_state", 32'(steer_state), 2);
    load('h0E0, 'h0E0);
    chk("steer_before_drop", 32'(steer_state), 2);
    tick();
    chk("drop_idle", 32'(steer_state), 0);
    chk("roff_not_yet", 32'(rider_off), 0);
    tick();
    chk("roff_pulse", 32'(rider_off), 1);
    chk("en_off", 32'(en_steer), 0);
    tick();
    chk("roff_one_clk", 32'(rider_off), 0);
    load('h0F8, 'h0F8);
    repeat (5) tick();
    chk("band_idle", 32'(steer_state), 0);
    load('h150, 'h150);
    tick();
    chk("rewait", 32'(steer_state), 1);
    repeat (10) tick();
    load('h200, 'h080);
    chk("imbal_diff", 32'($unsigned(load_cell_diff)), 'h180);
    load('h150, 'h150);
    n = 12;
    while (!en_steer && n < 60) begin tick(); n++; end
    chk("restart_latency", n, 29);
    load('h0F8, 'h0F8);
    repeat (5) tick();
    chk("band_steer", 32'(steer_state), 2);
    chk("band_en", 32'(en_steer), 1);
    load('h3F0, 'h000);
    chk("step_diff", 32'($unsigned(load_cell_diff)), 'h3F0);
    tick();
    chk("step_wait", 32'(steer_state), 1);
    tick();
    chk("step_en_off", 32'(en_steer), 0);
    chk("step_no_roff", 32'(rider_off), 0);
    load('h000, 'h3F0);
    chk("neg_diff", 32'($unsigned(load_cell_diff)), 'h1C10);
    load('h150, 'h150);
    repeat (20) tick();
    chk("pre_rst_steer", 32'(steer_state), 2);
    @(posedge clk);
    #4 rst = 1'b1;
    #1;
    chk("arst_en", 32'(en_steer), 0);
    chk("arst_state", 32'(steer_state), 0);
    chk("arst_diff", 32'($unsigned(load_cell_diff)), 0);
    chk("arst_roff", 32'(rider_off), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    tick();
    chk("post_rst_roff", 32'(rider_off), 0);
    load('h150, 'h150);
    tick();
    chk("post_rst_wait", 32'(steer_state), 1);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      load_vld = ($urandom_range(0, 19) == 0);
      k = $urandom_range(0, 9);
      if (k < 6) begin
        v = $urandom_range('h0E0, 'h160);
        lft_load  = 12'(v + $urandom_range(0, 40));
        rght_load = 12'(v + $urandom_range(0, 40));
      end else if (k < 8) begin
        lft_load  = 12'($urandom);
        rght_load = 12'($urandom);
      end else if (k == 8) begin
        lft_load  = 12'($urandom_range('h300, 'h400));
        rght_load = '0;
      end else begin
        lft_load  = '0;
        rght_load = 12'($urandom_range('h300, 'h400));
      end
      tick();
    end
    rst = 1'b0;
    load_vld = 1'b0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
